// File: rtl/alu_datapath_seq.sv
// ---------------------------------------------------------------------------
// alu_datapath_seq
//   Behavioural Am2901-style datapath: WIDTH-bit ALU, NREGS-word register
//   file, Q register and a registered {C,V,N,Z} status word. A repeat
//   sequencer can run one captured instruction N+1 times back-to-back
//   (multi-bit shifts, iterative multiply/divide steps).
//
// Ports
//   i_clk         clock
//   i_reset       synchronous active-high reset
//   i_instr       Am2901 I[8:0]: [2:0] source, [5:3] function, [8:6] dest
//   i_a_addr      A read address
//   i_b_addr      B read/write address
//   i_d           D bus
//   i_cin         carry in
//   i_half        1 = status taken from the low WIDTH/2 bits
//   i_status_en   1 = latch flags at each executed op
//   i_start       begin repeated execution
//   i_repeat_cnt  number of extra repetitions N
//   i_shift_fill  shift-in select
//   o_y           Y bus (combinational)
//   o_flags       registered {C,V,N,Z}
//   o_busy        repeat sequence in progress
//   o_done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module alu_datapath_seq #(
  parameter int WIDTH = 64,
  parameter int NREGS = 16,
  parameter int CNTW  = 6
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [8:0]               i_instr,
  input  logic [$clog2(NREGS)-1:0] i_a_addr,
  input  logic [$clog2(NREGS)-1:0] i_b_addr,
  input  logic [WIDTH-1:0]         i_d,
  input  logic                     i_cin,
  input  logic                     i_half,
  input  logic                     i_status_en,
  input  logic                     i_start,
  input  logic [CNTW-1:0]          i_repeat_cnt,
  input  logic [1:0]               i_shift_fill,
  output logic [WIDTH-1:0]         o_y,
  output logic [3:0]               o_flags,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int AW = $clog2(NREGS);
  localparam int H  = WIDTH / 2;

  localparam logic [2:0] SRC_AQ = 3'd0, SRC_AB = 3'd1, SRC_ZQ = 3'd2, SRC_ZB = 3'd3;
  localparam logic [2:0] SRC_ZA = 3'd4, SRC_DA = 3'd5, SRC_DQ = 3'd6, SRC_DZ = 3'd7;

  localparam logic [2:0] FN_ADD  = 3'd0, FN_SUBR = 3'd1, FN_SUBS = 3'd2, FN_OR   = 3'd3;
  localparam logic [2:0] FN_AND  = 3'd4, FN_NOTRS = 3'd5, FN_EXOR = 3'd6, FN_EXNOR = 3'd7;

  localparam logic [2:0] DST_QREG = 3'd0, DST_NOP  = 3'd1, DST_RAMA  = 3'd2, DST_RAMF = 3'd3;
  localparam logic [2:0] DST_RAMQD = 3'd4, DST_RAMD = 3'd5, DST_RAMQU = 3'd6, DST_RAMU = 3'd7;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_capture;

  // Operands captured at start, replayed while busy
  logic [8:0]        r_cap_instr;
  logic [AW-1:0]     r_cap_a_addr;
  logic [AW-1:0]     r_cap_b_addr;
  logic [WIDTH-1:0]  r_cap_d;
  logic              r_cap_cin;
  logic              r_cap_half;
  logic              r_cap_status_en;
  logic [1:0]        r_cap_fill;

  logic [WIDTH-1:0]  r_ram [NREGS];
  logic [WIDTH-1:0]  r_q;
  logic [3:0]        r_flags;

  // Effective controls: live inputs when idle, captured ones when busy
  logic              w_busy;
  logic [8:0]        w_instr;
  logic [AW-1:0]     w_a_addr;
  logic [AW-1:0]     w_b_addr;
  logic [WIDTH-1:0]  w_d;
  logic              w_cin;
  logic              w_half;
  logic              w_status_en;
  logic [1:0]        w_fill;

  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-1:0]  w_r;
  logic [WIDTH-1:0]  w_s;
  logic [WIDTH-1:0]  w_add_x;
  logic [WIDTH-1:0]  w_add_y;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH-1:0]  w_f;
  logic              w_is_arith;
  logic              w_c_full;
  logic              w_v_full;
  logic              w_c_half;
  logic              w_v_half;
  logic [3:0]        w_flags_nxt;

  logic              w_up_r0;
  logic              w_up_q0;
  logic              w_dn_rmsb;
  logic              w_dn_qmsb;
  logic              w_ram_we;
  logic [WIDTH-1:0]  w_ram_wd;
  logic              w_q_we;
  logic [WIDTH-1:0]  w_q_wd;

  assign w_busy      = (r_state == S_BUSY);
  assign w_instr     = w_busy ? r_cap_instr     : i_instr;
  assign w_a_addr    = w_busy ? r_cap_a_addr    : i_a_addr;
  assign w_b_addr    = w_busy ? r_cap_b_addr    : i_b_addr;
  assign w_d         = w_busy ? r_cap_d         : i_d;
  assign w_cin       = w_busy ? r_cap_cin       : i_cin;
  assign w_half      = w_busy ? r_cap_half      : i_half;
  assign w_status_en = w_busy ? r_cap_status_en : i_status_en;
  assign w_fill      = w_busy ? r_cap_fill      : i_shift_fill;

  assign w_a = r_ram[w_a_addr];
  assign w_b = r_ram[w_b_addr];

  // Sequencer next-state: start while idle captures; busy counts N cycles down
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_capture = 1'b1;
          if (i_repeat_cnt != {CNTW{1'b0}}) begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = i_repeat_cnt;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == {{(CNTW-1){1'b0}}, 1'b1}) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CNTW{1'b0}};
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - {{(CNTW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNTW{1'b0}};
      end
    endcase
  end

  // Sequencer state, capture registers and completion pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= {CNTW{1'b0}};
      r_done          <= 1'b0;
      r_cap_instr     <= 9'd0;
      r_cap_a_addr    <= {AW{1'b0}};
      r_cap_b_addr    <= {AW{1'b0}};
      r_cap_d         <= {WIDTH{1'b0}};
      r_cap_cin       <= 1'b0;
      r_cap_half      <= 1'b0;
      r_cap_status_en <= 1'b0;
      r_cap_fill      <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (w_capture) begin
        r_cap_instr     <= i_instr;
        r_cap_a_addr    <= i_a_addr;
        r_cap_b_addr    <= i_b_addr;
        r_cap_d         <= i_d;
        r_cap_cin       <= i_cin;
        r_cap_half      <= i_half;
        r_cap_status_en <= i_status_en;
        r_cap_fill      <= i_shift_fill;
      end
    end
  end

  // Source operand select (R, S)
  always_comb begin
    w_r = {WIDTH{1'b0}};
    w_s = {WIDTH{1'b0}};
    case (w_instr[2:0])
      SRC_AQ:  begin w_r = w_a;            w_s = r_q;            end
      SRC_AB:  begin w_r = w_a;            w_s = w_b;            end
      SRC_ZQ:  begin w_r = {WIDTH{1'b0}};  w_s = r_q;            end
      SRC_ZB:  begin w_r = {WIDTH{1'b0}};  w_s = w_b;            end
      SRC_ZA:  begin w_r = {WIDTH{1'b0}};  w_s = w_a;            end
      SRC_DA:  begin w_r = w_d;            w_s = w_a;            end
      SRC_DQ:  begin w_r = w_d;            w_s = r_q;            end
      SRC_DZ:  begin w_r = w_d;            w_s = {WIDTH{1'b0}};  end
      default: begin w_r = {WIDTH{1'b0}};  w_s = {WIDTH{1'b0}};  end
    endcase
  end

  // Adder operands: subtraction complements one side and reuses the carry in
  always_comb begin
    w_add_x = w_r;
    w_add_y = w_s;
    case (w_instr[5:3])
      FN_SUBR: begin w_add_x = ~w_r; w_add_y = w_s;  end
      FN_SUBS: begin w_add_x = w_r;  w_add_y = ~w_s; end
      default: begin w_add_x = w_r;  w_add_y = w_s;  end
    endcase
  end

  assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_cin};

  // Carry into bit k is recovered as sum[k] ^ x[k] ^ y[k]
  assign w_c_full = w_sum[WIDTH];
  assign w_v_full = w_sum[WIDTH] ^ (w_sum[WIDTH-1] ^ w_add_x[WIDTH-1] ^ w_add_y[WIDTH-1]);
  assign w_c_half = w_sum[H] ^ w_add_x[H] ^ w_add_y[H];
  assign w_v_half = w_c_half ^ (w_sum[H-1] ^ w_add_x[H-1] ^ w_add_y[H-1]);

  // ALU function
  always_comb begin
    w_f        = {WIDTH{1'b0}};
    w_is_arith = 1'b0;
    case (w_instr[5:3])
      FN_ADD, FN_SUBR, FN_SUBS: begin
        w_f        = w_sum[WIDTH-1:0];
        w_is_arith = 1'b1;
      end
      FN_OR:    w_f = w_r | w_s;
      FN_AND:   w_f = w_r & w_s;
      FN_NOTRS: w_f = ~w_r & w_s;
      FN_EXOR:  w_f = w_r ^ w_s;
      FN_EXNOR: w_f = ~(w_r ^ w_s);
      default:  w_f = {WIDTH{1'b0}};
    endcase
  end

  // Status word {C,V,N,Z} from the full or half-width result
  always_comb begin
    w_flags_nxt = 4'd0;
    if (w_half) begin
      w_flags_nxt[3] = w_is_arith & w_c_half;
      w_flags_nxt[2] = w_is_arith & w_v_half;
      w_flags_nxt[1] = w_f[H-1];
      w_flags_nxt[0] = (w_f[H-1:0] == {H{1'b0}});
    end else begin
      w_flags_nxt[3] = w_is_arith & w_c_full;
      w_flags_nxt[2] = w_is_arith & w_v_full;
      w_flags_nxt[1] = w_f[WIDTH-1];
      w_flags_nxt[0] = (w_f == {WIDTH{1'b0}});
    end
  end

  // Shift-in bits; fill 3 links F and Q like the Am2904 shift mux
  always_comb begin
    w_up_r0   = 1'b0;
    w_up_q0   = 1'b0;
    w_dn_rmsb = 1'b0;
    w_dn_qmsb = 1'b0;
    case (w_fill)
      2'd0: begin
        w_up_r0 = 1'b0;         w_up_q0 = 1'b0;
        w_dn_rmsb = 1'b0;       w_dn_qmsb = 1'b0;
      end
      2'd1: begin
        w_up_r0 = 1'b1;         w_up_q0 = 1'b1;
        w_dn_rmsb = 1'b1;       w_dn_qmsb = 1'b1;
      end
      2'd2: begin
        w_up_r0 = w_f[WIDTH-1]; w_up_q0 = r_q[WIDTH-1];
        w_dn_rmsb = w_f[0];     w_dn_qmsb = r_q[0];
      end
      2'd3: begin
        w_up_r0 = r_q[WIDTH-1]; w_up_q0 = 1'b0;
        w_dn_rmsb = w_f[WIDTH-1]; w_dn_qmsb = w_f[0];
      end
      default: begin
        w_up_r0 = 1'b0;         w_up_q0 = 1'b0;
        w_dn_rmsb = 1'b0;       w_dn_qmsb = 1'b0;
      end
    endcase
  end

  // Destination decode: write enables and write data for RAM[B] and Q
  always_comb begin
    w_ram_we = 1'b0;
    w_ram_wd = w_f;
    w_q_we   = 1'b0;
    w_q_wd   = w_f;
    case (w_instr[8:6])
      DST_QREG:  begin w_q_we = 1'b1; w_q_wd = w_f; end
      DST_NOP:   begin w_ram_we = 1'b0; w_q_we = 1'b0; end
      DST_RAMA:  begin w_ram_we = 1'b1; w_ram_wd = w_f; end
      DST_RAMF:  begin w_ram_we = 1'b1; w_ram_wd = w_f; end
      DST_RAMQD: begin
        w_ram_we = 1'b1; w_ram_wd = {w_dn_rmsb, w_f[WIDTH-1:1]};
        w_q_we   = 1'b1; w_q_wd   = {w_dn_qmsb, r_q[WIDTH-1:1]};
      end
      DST_RAMD:  begin w_ram_we = 1'b1; w_ram_wd = {w_dn_rmsb, w_f[WIDTH-1:1]}; end
      DST_RAMQU: begin
        w_ram_we = 1'b1; w_ram_wd = {w_f[WIDTH-2:0], w_up_r0};
        w_q_we   = 1'b1; w_q_wd   = {r_q[WIDTH-2:0], w_up_q0};
      end
      DST_RAMU:  begin w_ram_we = 1'b1; w_ram_wd = {w_f[WIDTH-2:0], w_up_r0}; end
      default:   begin w_ram_we = 1'b0; w_q_we = 1'b0; end
    endcase
  end

  // Register file, Q and status word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_ram[i] <= {WIDTH{1'b0}};
      end
      r_q     <= {WIDTH{1'b0}};
      r_flags <= 4'd0;
    end else begin
      if (w_ram_we) begin
        r_ram[w_b_addr] <= w_ram_wd;
      end
      if (w_q_we) begin
        r_q <= w_q_wd;
      end
      if (w_status_en) begin
        r_flags <= w_flags_nxt;
      end
    end
  end

  assign o_y     = (w_instr[8:6] == DST_RAMA) ? w_a : w_f;
  assign o_flags = r_flags;
  assign o_busy  = w_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_alu_datapath_seq.sv
module tb_alu_datapath_seq;

  localparam int W = 64;

  localparam logic [2:0] S_AQ = 3'd0, S_AB = 3'd1, S_ZQ = 3'd2, S_ZB = 3'd3;
  localparam logic [2:0] S_ZA = 3'd4, S_DA = 3'd5, S_DQ = 3'd6, S_DZ = 3'd7;
  localparam logic [2:0] F_ADD = 3'd0, F_OR = 3'd3;
  localparam logic [2:0] D_QREG = 3'd0, D_NOP = 3'd1, D_RAMF = 3'd3;
  localparam logic [2:0] D_RAMQD = 3'd4, D_RAMQU = 3'd6, D_RAMU = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    instr;
  logic [3:0]    a_addr;
  logic [3:0]    b_addr;
  logic [W-1:0]  d;
  logic          cin;
  logic          half;
  logic          status_en;
  logic          start;
  logic [5:0]    repeat_cnt;
  logic [1:0]    shift_fill;
  logic [W-1:0]  y;
  logic [3:0]    flags;
  logic          busy;
  logic          done;

  typedef struct {
    string        tag;
    int           sel;
    logic [W-1:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_datapath_seq #(.WIDTH(64), .NREGS(16), .CNTW(6)) dut (
    .i_clk(clk), .i_reset(reset), .i_instr(instr), .i_a_addr(a_addr),
    .i_b_addr(b_addr), .i_d(d), .i_cin(cin), .i_half(half),
    .i_status_en(status_en), .i_start(start), .i_repeat_cnt(repeat_cnt),
    .i_shift_fill(shift_fill), .o_y(y), .o_flags(flags), .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      0:       observe = y;
      1:       observe = {60'd0, flags};
      2:       observe = {63'd0, busy};
      3:       observe = {63'd0, done};
      default: observe = 64'd0;
    endcase
  endfunction

  function automatic logic [8:0] mk(input logic [2:0] dst, input logic [2:0] fn, input logic [2:0] src);
    return {dst, fn, src};
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [W-1:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr = mk(D_NOP, F_OR, S_ZB);
    a_addr = 4'd0; b_addr = 4'd0; d = 64'd0; cin = 1'b0; half = 1'b0;
    status_en = 1'b0; start = 1'b0; repeat_cnt = 6'd0; shift_fill = 2'd0;
  endtask

  task automatic load(input int k, input logic [W-1:0] v);
    idle_inputs();
    instr = mk(D_RAMF, F_OR, S_DZ);
    b_addr = 4'(k);
    d = v;
    tick();
  endtask

  task automatic load_q(input logic [W-1:0] v);
    idle_inputs();
    instr = mk(D_QREG, F_OR, S_DZ);
    d = v;
    tick();
  endtask

  task automatic read_reg(input string tag, input int k, input logic [W-1:0] exp);
    idle_inputs();
    b_addr = 4'(k);
    expect_out(tag, 0, exp);
    drain();
  endtask

  task automatic read_q(input string tag, input logic [W-1:0] exp);
    idle_inputs();
    instr = mk(D_NOP, F_OR, S_ZQ);
    expect_out(tag, 0, exp);
    drain();
  endtask

  initial begin
    logic [W-1:0] av, dv, e, rv, qv, er, eq;
    logic         c;
    logic [2:0]   fn;

    // 1. reset state and first load
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    expect_out("rst_flags", 1, 64'd0);
    expect_out("rst_busy", 2, 64'd0);
    expect_out("rst_done", 3, 64'd0);
    drain();
    instr = mk(D_RAMF, F_OR, S_DZ); d = 64'h1234; b_addr = 4'd3; status_en = 1'b1;
    expect_out("t1_y", 0, 64'h1234);
    drain();
    tick();
    expect_out("t1_flags", 1, 64'd0);
    drain();
    read_reg("t1_r3", 3, 64'h1234);

    // ALU functions against a reference, D and A operands
    for (int p = 0; p < 2; p++) begin
      av = {$urandom(), $urandom()};
      dv = {$urandom(), $urandom()};
      load(9, av);
      for (int f = 0; f < 8; f++) begin
        fn = 3'(f);
        c = fn[0];
        idle_inputs();
        instr = mk(D_NOP, fn, S_DA); a_addr = 4'd9; d = dv; cin = c;
        case (fn)
          3'd0:    e = dv + av + {63'd0, c};
          3'd1:    e = av + ~dv + {63'd0, c};
          3'd2:    e = dv + ~av + {63'd0, c};
          3'd3:    e = dv | av;
          3'd4:    e = dv & av;
          3'd5:    e = ~dv & av;
          3'd6:    e = dv ^ av;
          default: e = ~(dv ^ av);
        endcase
        expect_out($sformatf("alu_fn%0d_p%0d", f, p), 0, e);
        drain();
      end
    end

    // 2. half / full status on 0xFFFF_FFFF + 1
    load(1, 64'hFFFF_FFFF);
    load(2, 64'd1);
    idle_inputs();
    instr = mk(D_RAMF, F_ADD, S_AB); a_addr = 4'd1; b_addr = 4'd2; half = 1'b1; status_en = 1'b1;
    tick();
    expect_out("t2_half_flags", 1, 64'b1001);
    drain();
    load(2, 64'd1);
    idle_inputs();
    instr = mk(D_RAMF, F_ADD, S_AB); a_addr = 4'd1; b_addr = 4'd2; half = 1'b0; status_en = 1'b1;
    tick();
    expect_out("t2_full_flags", 1, 64'b0000);
    drain();
    read_reg("t2_r2", 2, 64'h1_0000_0000);

    // 3. signed overflow, then status hold
    load(5, 64'h7FFF_FFFF_FFFF_FFFF);
    idle_inputs();
    instr = mk(D_RAMF, F_ADD, S_ZB); b_addr = 4'd5; cin = 1'b1; status_en = 1'b1;
    tick();
    expect_out("t3_ovf_flags", 1, 64'b0110);
    drain();
    idle_inputs();
    instr = mk(D_NOP, F_OR, S_DZ); d = 64'd0; status_en = 1'b0;
    tick();
    expect_out("t3_hold_flags", 1, 64'b0110);
    drain();
    read_reg("t3_r5", 5, 64'h8000_0000_0000_0000);

    // 4. repeated up shift, N=7, live inputs disturbed while busy
    load(4, 64'd1);
    idle_inputs();
    instr = mk(D_RAMU, F_OR, S_ZB); b_addr = 4'd4; start = 1'b1; repeat_cnt = 6'd7;
    expect_out("t4_y0", 0, 64'd1);
    drain();
    tick();
    for (int i = 1; i <= 7; i++) begin
      instr = mk(D_RAMF, F_OR, S_DZ); d = 64'hDEAD; b_addr = 4'd4;
      start = 1'b1; repeat_cnt = 6'd3; status_en = 1'b1;
      expect_out($sformatf("t4_busy_c%0d", i), 2, 64'd1);
      expect_out($sformatf("t4_done_c%0d", i), 3, 64'd0);
      expect_out($sformatf("t4_y_c%0d", i), 0, 64'd1 << i);
      drain();
      tick();
    end
    idle_inputs();
    b_addr = 4'd4;
    expect_out("t4_done_c8", 3, 64'd1);
    expect_out("t4_busy_c8", 2, 64'd0);
    expect_out("t4_r4", 0, 64'h100);
    drain();
    tick();
    expect_out("t4_done_c9", 3, 64'd0);
    drain();

    // 5. linked down shift
    load(6, 64'h8000_0000_0000_0003);
    load_q(64'd0);
    idle_inputs();
    instr = mk(D_RAMQD, F_OR, S_ZB); b_addr = 4'd6; shift_fill = 2'd3;
    tick();
    read_reg("t5_r6", 6, 64'hC000_0000_0000_0001);
    read_q("t5_q", 64'h8000_0000_0000_0000);

    // all fill modes, both directions, two operand sets
    for (int set = 0; set < 2; set++) begin
      for (int dir = 0; dir < 2; dir++) begin
        for (int fl = 0; fl < 4; fl++) begin
          rv = (set == 0) ? 64'h9234_5678_9ABC_DEF1 : 64'h1234_5678_9ABC_DEF0;
          qv = (set == 0) ? 64'hC0FF_EE00_1234_5678 : 64'h40FF_EE00_1234_5679;
          load(8, rv);
          load_q(qv);
          idle_inputs();
          instr = mk((dir == 0) ? D_RAMQU : D_RAMQD, F_OR, S_ZB);
          b_addr = 4'd8; shift_fill = 2'(fl);
          tick();
          if (dir == 0) begin
            case (fl)
              0:       begin er = {rv[62:0], 1'b0};   eq = {qv[62:0], 1'b0};   end
              1:       begin er = {rv[62:0], 1'b1};   eq = {qv[62:0], 1'b1};   end
              2:       begin er = {rv[62:0], rv[63]}; eq = {qv[62:0], qv[63]}; end
              default: begin er = {rv[62:0], qv[63]}; eq = {qv[62:0], 1'b0};   end
            endcase
          end else begin
            case (fl)
              0:       begin er = {1'b0, rv[63:1]};   eq = {1'b0, qv[63:1]};   end
              1:       begin er = {1'b1, rv[63:1]};   eq = {1'b1, qv[63:1]};   end
              2:       begin er = {rv[0], rv[63:1]};  eq = {qv[0], qv[63:1]};  end
              default: begin er = {rv[63], rv[63:1]}; eq = {rv[0], qv[63:1]};  end
            endcase
          end
          read_reg($sformatf("shf_r_s%0d_d%0d_f%0d", set, dir, fl), 8, er);
          read_q($sformatf("shf_q_s%0d_d%0d_f%0d", set, dir, fl), eq);
        end
      end
    end

    // 6. reset aborts a running sequence, then N=0 start
    load(7, 64'd1);
    idle_inputs();
    instr = mk(D_RAMU, F_OR, S_ZB); b_addr = 4'd7; start = 1'b1; repeat_cnt = 6'd10;
    tick();
    idle_inputs();
    expect_out("t6_busy_c1", 2, 64'd1);
    drain();
    tick();
    tick();
    reset = 1'b1;
    expect_out("t6_busy_c3", 2, 64'd1);
    drain();
    tick();
    reset = 1'b0;
    expect_out("t6_abort_busy", 2, 64'd0);
    expect_out("t6_abort_done", 3, 64'd0);
    expect_out("t6_abort_flags", 1, 64'd0);
    drain();
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out($sformatf("t6_nodone_%0d", i), 3, 64'd0);
      drain();
    end
    for (int k = 0; k < 16; k++) begin
      read_reg($sformatf("t6_r%0d_clr", k), k, 64'd0);
    end
    read_q("t6_q_clr", 64'd0);
    idle_inputs();
    start = 1'b1; repeat_cnt = 6'd0;
    tick();
    start = 1'b0;
    expect_out("t6_n0_done", 3, 64'd1);
    expect_out("t6_n0_busy", 2, 64'd0);
    drain();
    tick();
    expect_out("t6_n0_done_clr", 3, 64'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
